sram_mem_controller: RTL and testbench

- Memory-stage controller that replaces the single-cycle data array with an external word-wide SRAM that needs multi-cycle access.
- Sits between the EXE/MEM pipeline register and the MEM/WB register.
- Takes the same MEM request signals the memory stage consumes (MEM_R_EN, MEM_W_EN, alu_res, rm_val) and returns data_mem.
- Drives a `ready` signal; the hazard/freeze logic stalls all earlier pipeline stages while `ready` is low.

---
 rtl/sram_mem_controller.sv | 125 ++++++++++++
 tb/tb_sram_mem_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Memory-stage controller that fronts a multi-cycle word-wide SRAM and stalls the pipeline via ready.
// Optional feature macro: SRAM_POSTED_WRITE_EN (stores retire without a stall and complete in the background).
module sram_mem_controller #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       rm_val,
    output logic [31:0]       data_mem,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              write_q;
    logic              req;
    logic              last_beat;
    logic [ADDR_W-1:0] word_addr;

    assign req       = MEM_R_EN | MEM_W_EN;
    assign last_beat = (cnt_q == 4'(WAIT_CYCLES - 1));
    // Out-of-window addresses wrap silently; the byte offset bits are dropped.
    assign word_addr = ADDR_W'((alu_res - 32'(BASE_ADDR)) >> 2);

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= word_addr;
                        wdata_q <= rm_val;
                        write_q <= MEM_W_EN;
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (last_beat && !write_q) begin
                        rdata_q <= sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        data_mem  = '0;
        unique case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d = ACCESS;
                end
`ifdef SRAM_POSTED_WRITE_EN
                if (MEM_W_EN) begin
                    ready = 1'b1;
                end
`endif
            end
            ACCESS: begin
                sram_we_n = ~write_q;
                sram_oe_n = write_q;
`ifdef SRAM_POSTED_WRITE_EN
                // A posted store already retired; only a new request has to wait for it.
                if (write_q) begin
                    ready = ~req;
                end
                if (last_beat) begin
                    state_d = write_q ? IDLE : DONE;
                end
`else
                if (last_beat) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                ready    = 1'b1;
                data_mem = write_q ? 32'd0 : rdata_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed self-checking bench for sram_mem_controller with a behavioural SRAM model (WAIT_CYCLES=5).
// Define SRAM_POSTED_WRITE_EN for both RTL and bench to exercise the posted-write build.
module tb_sram_mem_controller;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] alu_res;
    logic [31:0] rm_val;
    logic [31:0] data_mem;
    logic        ready;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [31:0] sram_rdata;

    int checks;
    int errors;

    logic [31:0] mem [0:65535];

    sram_mem_controller #(
        .ADDR_W     (16),
        .WAIT_CYCLES(5),
        .BASE_ADDR  (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .alu_res   (alu_res),
        .rm_val    (rm_val),
        .data_mem  (data_mem),
        .ready     (ready),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM, synchronous write while we_n is low.
    assign sram_rdata = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_wdata;
    end

    // Drives one request from IDLE (called just after a rising edge) and observes it until ready rises.
    task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                             output int low, output int we, output int oe,
                             output logic [31:0] dm, output logic [15:0] sa, output logic [31:0] swd);
        low = 0; we = 0; oe = 0; dm = '0; sa = '0; swd = '0;
        MEM_R_EN = r; MEM_W_EN = w; alu_res = a; rm_val = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!sram_we_n) begin we++; sa = sram_addr; swd = sram_wdata; end
            if (!sram_oe_n) begin oe++; sa = sram_addr; end
            if (ready) begin dm = data_mem; break; end
            low++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b expected 1", sram_oe_n); end
        checks++; if (sram_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", sram_addr); end
        checks++; if (data_mem !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", data_mem); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        int low, we, oe; logic [31:0] dm, swd; logic [15:0] sa;
        do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, low, we, oe, dm, sa, swd);
        checks++; if (low !== 6) begin errors++; $display("FAIL store_stall: got %0d expected 6", low); end
        checks++; if (we !== 5) begin errors++; $display("FAIL store_we_cycles: got %0d expected 5", we); end
        checks++; if (oe !== 0) begin errors++; $display("FAIL store_oe_cycles: got %0d expected 0", oe); end
        checks++; if (sa !== 16'd2) begin errors++; $display("FAIL store_addr: got %h expected 0002", sa); end
        checks++; if (swd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h expected deadbeef", swd); end
        checks++; if (dm !== 32'h0) begin errors++; $display("FAIL store_done_data: got %h expected 00000000", dm); end
        checks++; if (mem[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_sram: got %h expected deadbeef", mem[2]); end
    endtask

    task automatic test_load();
        int low, we, oe; logic [31:0] dm, swd; logic [15:0] sa;
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, low, we, oe, dm, sa, swd);
        checks++; if (low !== 6) begin errors++; $display("FAIL load_stall: got %0d expected 6", low); end
        checks++; if (oe !== 5) begin errors++; $display("FAIL load_oe_cycles: got %0d expected 5", oe); end
        checks++; if (we !== 0) begin errors++; $display("FAIL load_we_cycles: got %0d expected 0", we); end
        checks++; if (sa !== 16'd2) begin errors++; $display("FAIL load_addr: got %h expected 0002", sa); end
        checks++; if (dm !== 32'hDEADBEEF) begin errors++; $display("FAIL load_done_data: got %h expected deadbeef", dm); end
        @(negedge clk);
        checks++; if (data_mem !== 32'h0) begin errors++; $display("FAIL load_after_data: got %h expected 00000000", data_mem); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_after_ready: got %b expected 1", ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_both_enables();
        int low, we, oe; logic [31:0] dm, swd; logic [15:0] sa;
        do_access(1'b1, 1'b1, 32'd1024, 32'd7, low, we, oe, dm, sa, swd);
        checks++; if (we !== 5) begin errors++; $display("FAIL both_we_cycles: got %0d expected 5", we); end
        checks++; if (oe !== 0) begin errors++; $display("FAIL both_oe_cycles: got %0d expected 0", oe); end
        checks++; if (sa !== 16'd0) begin errors++; $display("FAIL both_addr: got %h expected 0000", sa); end
        checks++; if (dm !== 32'h0) begin errors++; $display("FAIL both_done_data: got %h expected 00000000", dm); end
        checks++; if (mem[0] !== 32'd7) begin errors++; $display("FAIL both_sram: got %h expected 00000007", mem[0]); end
    endtask

    task automatic test_reset_mid_access();
        MEM_W_EN = 1'b1; alu_res = 32'd1040; rm_val = 32'h55;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midrst_pre_we_n: got %b expected 0", sram_we_n); end
        rst = 1'b1;
        #1;
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL midrst_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_addr !== 16'h0) begin errors++; $display("FAIL midrst_addr: got %h expected 0000", sram_addr); end
        checks++; if (sram_wdata !== 32'h0) begin errors++; $display("FAIL midrst_wdata: got %h expected 00000000", sram_wdata); end
        MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL midrst_oe_n: got %b expected 1", sram_oe_n); end
        checks++; if (data_mem !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 00000000", data_mem); end
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int low, we, oe; logic [31:0] dm, swd; logic [15:0] sa;
        do_access(1'b1, 1'b0, 32'd1020, 32'h0, low, we, oe, dm, sa, swd);
        checks++; if (sa !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr: got %h expected ffff", sa); end
        checks++; if (oe !== 5) begin errors++; $display("FAIL wrap_oe_cycles: got %0d expected 5", oe); end
        checks++; if (low !== 6) begin errors++; $display("FAIL wrap_stall: got %0d expected 6", low); end
        checks++; if (dm !== 32'hA5A50F0F) begin errors++; $display("FAIL wrap_data: got %h expected a5a50f0f", dm); end
    endtask

    task automatic test_back_to_back();
        int low, we, oe; logic [31:0] dm, swd; logic [15:0] sa;
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, low, we, oe, dm, sa, swd);
        checks++; if (dm !== 32'h12345678) begin errors++; $display("FAIL b2b_first_data: got %h expected 12345678", dm); end
        checks++; if (low !== 6) begin errors++; $display("FAIL b2b_first_stall: got %0d expected 6", low); end
        do_access(1'b1, 1'b0, 32'd1023, 32'h0, low, we, oe, dm, sa, swd);
        checks++; if (dm !== 32'hA5A50F0F) begin errors++; $display("FAIL b2b_second_data: got %h expected a5a50f0f", dm); end
        checks++; if (low !== 6) begin errors++; $display("FAIL b2b_second_stall: got %0d expected 6", low); end
    endtask

`ifdef SRAM_POSTED_WRITE_EN
    task automatic test_posted_write();
        int low, we, oe; logic [31:0] dm, swd; logic [15:0] sa;
        MEM_W_EN = 1'b1; alu_res = 32'd1028; rm_val = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL posted_ready: got %b expected 1", ready); end
        @(posedge clk); #1;
        MEM_W_EN = 1'b0;
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, low, we, oe, dm, sa, swd);
        checks++; if (low !== 11) begin errors++; $display("FAIL posted_load_stall: got %0d expected 11", low); end
        checks++; if (we !== 5) begin errors++; $display("FAIL posted_we_cycles: got %0d expected 5", we); end
        checks++; if (oe !== 5) begin errors++; $display("FAIL posted_oe_cycles: got %0d expected 5", oe); end
        checks++; if (sa !== 16'd1) begin errors++; $display("FAIL posted_addr: got %h expected 0001", sa); end
        checks++; if (dm !== 32'hCAFEF00D) begin errors++; $display("FAIL posted_load_data: got %h expected cafef00d", dm); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'hFFFF] = 32'hA5A50F0F;
        mem[3]        = 32'h12345678;
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; alu_res = '0; rm_val = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_idle();
`ifdef SRAM_POSTED_WRITE_EN
        test_posted_write();
`else
        test_store();
        test_load();
        test_both_enables();
        test_reset_mid_access();
`endif
        test_wrap();
        test_back_to_back();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
